// File: rtl/sine_nco_sweep_ctrl.sv
// rtl/sine_nco_sweep_ctrl.sv - frequency-sweep sequencer driving the sine NCO phase increment
module sine_nco_sweep_ctrl #(
    parameter int APR       = 32,
    parameter int DWW       = 16,
    parameter int PRIME_MAX = 64
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start_i,
    input  logic           abort_i,
    input  logic [1:0]     mode_i,
    input  logic [APR-1:0] f_start_i,
    input  logic [APR-1:0] f_stop_i,
    input  logic [APR-1:0] f_step_i,
    input  logic [DWW-1:0] dwell_i,
    input  logic           nco_out_valid_i,
    output logic           clken_o,
    output logic [APR-1:0] phi_inc_o,
    output logic           busy_o,
    output logic           sweep_valid_o,
    output logic           done_o,
    output logic           err_o
);

    localparam int PTW = (PRIME_MAX > 1) ? $clog2(PRIME_MAX) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_SWEEP
    } state_t;

    state_t         state;
    logic [APR-1:0] cfg_start;
    logic [APR-1:0] cfg_stop;
    logic [APR-1:0] cfg_step;
    logic [DWW-1:0] cfg_dwell;
    logic [1:0]     cfg_mode;
    logic           cfg_up;
    logic [DWW-1:0] dwell_cnt;
    logic [PTW-1:0] prime_timer;

    logic           dwell_last;
    logic           at_stop;
    logic [APR-1:0] next_fwd;
    logic [APR-1:0] next_rev;

    // One step toward target, saturating at target; the extra bit catches wrap.
    function automatic logic [APR-1:0] step_toward(
        input logic [APR-1:0] cur,
        input logic [APR-1:0] step,
        input logic [APR-1:0] target,
        input logic           up
    );
        logic [APR:0]   ext;
        logic [APR-1:0] res;
        if (up) begin
            ext = {1'b0, cur} + {1'b0, step};
            res = (ext[APR] || (ext[APR-1:0] > target)) ? target : ext[APR-1:0];
        end else begin
            ext = {1'b0, cur} - {1'b0, step};
            res = (ext[APR] || (ext[APR-1:0] < target)) ? target : ext[APR-1:0];
        end
        return res;
    endfunction

    assign dwell_last = (cfg_dwell == '0) || (dwell_cnt == cfg_dwell - DWW'(1));
    assign at_stop    = (phi_inc_o == cfg_stop);
    assign next_fwd   = step_toward(phi_inc_o, cfg_step, cfg_stop, cfg_up);
    assign next_rev   = step_toward(phi_inc_o, cfg_step, cfg_start, ~cfg_up);

    assign clken_o       = (state != ST_IDLE);
    assign busy_o        = (state != ST_IDLE);
    assign sweep_valid_o = nco_out_valid_i && (state == ST_SWEEP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cfg_start   <= '0;
            cfg_stop    <= '0;
            cfg_step    <= '0;
            cfg_dwell   <= '0;
            cfg_mode    <= '0;
            cfg_up      <= 1'b0;
            dwell_cnt   <= '0;
            prime_timer <= '0;
            phi_inc_o   <= '0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (abort_i) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_i) begin
                            state       <= ST_PRIME;
                            cfg_start   <= f_start_i;
                            cfg_stop    <= f_stop_i;
                            cfg_step    <= f_step_i;
                            cfg_dwell   <= dwell_i;
                            cfg_mode    <= mode_i;
                            cfg_up      <= (f_stop_i >= f_start_i);
                            phi_inc_o   <= f_start_i;
                            prime_timer <= '0;
                            err_o       <= 1'b0;
                        end
                    end
                    ST_PRIME: begin
                        if (nco_out_valid_i) begin
                            state     <= ST_SWEEP;
                            dwell_cnt <= '0;
                        end else if (prime_timer == PTW'(PRIME_MAX - 1)) begin
                            state <= ST_IDLE;
                            err_o <= 1'b1;
                        end else begin
                            prime_timer <= prime_timer + PTW'(1);
                        end
                    end
                    ST_SWEEP: begin
                        if (dwell_last) begin
                            dwell_cnt <= '0;
                            if (at_stop) begin
                                case (cfg_mode)
                                    2'b01: phi_inc_o <= cfg_start;
                                    2'b10: begin
                                        // Turn around: the old start becomes the new target.
                                        cfg_start <= cfg_stop;
                                        cfg_stop  <= cfg_start;
                                        cfg_up    <= ~cfg_up;
                                        phi_inc_o <= next_rev;
                                    end
                                    default: begin
                                        done_o <= 1'b1;
                                        state  <= ST_IDLE;
                                    end
                                endcase
                            end else begin
                                phi_inc_o <= next_fwd;
                            end
                        end else begin
                            dwell_cnt <= dwell_cnt + DWW'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sine_nco_sweep_ctrl.sv
// tb/tb_sine_nco_sweep_ctrl.sv - directed scoreboard bench for sine_nco_sweep_ctrl
module tb_sine_nco_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_i;
    logic        abort_i;
    logic [1:0]  mode_i;
    logic [31:0] f_start_i;
    logic [31:0] f_stop_i;
    logic [31:0] f_step_i;
    logic [15:0] dwell_i;
    logic        nco_out_valid_i;
    logic        clken_o;
    logic [31:0] phi_inc_o;
    logic        busy_o;
    logic        sweep_valid_o;
    logic        done_o;
    logic        err_o;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_done;
    logic [31:0] exp_q[$];

    sine_nco_sweep_ctrl #(.APR(32), .DWW(16), .PRIME_MAX(64)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .mode_i         (mode_i),
        .f_start_i      (f_start_i),
        .f_stop_i       (f_stop_i),
        .f_step_i       (f_step_i),
        .dwell_i        (dwell_i),
        .nco_out_valid_i(nco_out_valid_i),
        .clken_o        (clken_o),
        .phi_inc_o      (phi_inc_o),
        .busy_o         (busy_o),
        .sweep_valid_o  (sweep_valid_o),
        .done_o         (done_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic start_sweep(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                               input logic [15:0] dw, input logic [1:0] md);
        @(negedge clk);
        f_start_i = fs; f_stop_i = fe; f_step_i = st; dwell_i = dw; mode_i = md;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        f_start_i = 32'h5a5a; f_stop_i = 32'h1; f_step_i = 32'h3; dwell_i = 16'd9; mode_i = 2'b11;
        chk("prime_busy", {31'd0, busy_o}, 32'd1);
        chk("prime_phi", phi_inc_o, fs);
        chk("prime_err", {31'd0, err_o}, 32'd0);
        chk("prime_no_sweep_valid", {31'd0, sweep_valid_o}, 32'd0);
    endtask

    task automatic push_rep(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    task automatic collect(input string tag, input int budget);
        int c;
        c = 0;
        n_done = 0;
        while (exp_q.size() > 0 && c < budget) begin
            @(negedge clk);
            c++;
            if (done_o) n_done++;
            if (sweep_valid_o) chk(tag, phi_inc_o, exp_q.pop_front());
        end
        if (exp_q.size() != 0) begin
            chk({tag, "_budget"}, exp_q.size(), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic abort_and_check(input string tag, input logic [31:0] held);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_clken"}, {31'd0, clken_o}, 32'd0);
        chk({tag, "_phi_held"}, phi_inc_o, held);
        chk({tag, "_no_done"}, {31'd0, done_o}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; mode_i = 2'b00;
        f_start_i = '0; f_stop_i = '0; f_step_i = '0; dwell_i = '0; nco_out_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_phi", phi_inc_o, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        reset_n = 1'b1;

        // single up with NCO valid arriving late in PRIME
        start_sweep(32'd100, 32'd130, 32'd10, 16'd4, 2'b00);
        push_rep(32'd100, 4); push_rep(32'd110, 4); push_rep(32'd120, 4); push_rep(32'd130, 4);
        repeat (3) @(negedge clk);
        chk("late_valid_still_prime", {31'd0, busy_o}, 32'd1);
        nco_out_valid_i = 1'b1;
        collect("single_up", 40);
        chk("single_up_no_early_done", n_done, 32'd0);
        @(negedge clk);
        chk("single_up_done", {31'd0, done_o}, 32'd1);
        chk("single_up_clken_off", {31'd0, clken_o}, 32'd0);
        chk("single_up_phi_stop", phi_inc_o, 32'd130);
        @(negedge clk);
        chk("single_up_done_1cyc", {31'd0, done_o}, 32'd0);

        // clamp down and top-of-range wrap guard
        start_sweep(32'd50, 32'd7, 32'd20, 16'd1, 2'b00);
        exp_q.push_back(32'd50); exp_q.push_back(32'd30); exp_q.push_back(32'd10); exp_q.push_back(32'd7);
        collect("clamp_down", 20);
        @(negedge clk);
        chk("clamp_down_done", {31'd0, done_o}, 32'd1);
        start_sweep(32'hffff_fffb, 32'hffff_ffff, 32'd16, 16'd2, 2'b11);
        push_rep(32'hffff_fffb, 2); push_rep(32'hffff_ffff, 2);
        collect("wrap_guard", 20);
        @(negedge clk);
        chk("wrap_guard_done", {31'd0, done_o}, 32'd1);
        chk("wrap_guard_phi", phi_inc_o, 32'hffff_ffff);

        // ping-pong and repeat, then abort mid-sweep
        start_sweep(32'd0, 32'd30, 32'd10, 16'd1, 2'b10);
        foreach (exp_q[i]) exp_q.delete();
        exp_q = '{32'd0, 32'd10, 32'd20, 32'd30, 32'd20, 32'd10, 32'd0, 32'd10, 32'd20};
        collect("ping_pong", 30);
        chk("ping_pong_no_done", n_done, 32'd0);
        abort_and_check("pp_abort", 32'd20);
        start_sweep(32'd0, 32'd30, 32'd10, 16'd1, 2'b01);
        exp_q = '{32'd0, 32'd10, 32'd20, 32'd30, 32'd0, 32'd10};
        collect("repeat", 30);
        chk("repeat_no_done", n_done, 32'd0);
        abort_and_check("rep_abort", 32'd10);

        // zero step holds f_start and never ends
        start_sweep(32'd5, 32'd9, 32'd0, 16'd1, 2'b00);
        push_rep(32'd5, 6);
        collect("step0_hold", 20);
        chk("step0_no_done", n_done, 32'd0);
        abort_and_check("step0_abort", 32'd5);

        // prime timeout
        nco_out_valid_i = 1'b0;
        start_sweep(32'd42, 32'd99, 32'd1, 16'd1, 2'b00);
        repeat (63) @(negedge clk);
        chk("timeout_last_prime", {31'd0, busy_o}, 32'd1);
        @(negedge clk);
        chk("timeout_idle", {31'd0, busy_o}, 32'd0);
        chk("timeout_err", {31'd0, err_o}, 32'd1);
        repeat (3) @(negedge clk);
        chk("timeout_err_sticky", {31'd0, err_o}, 32'd1);
        nco_out_valid_i = 1'b1;
        start_sweep(32'd64, 32'd70, 32'd1, 16'd1, 2'b00);
        abort_and_check("prime_abort", 32'd64);

        // abort beats start in IDLE
        @(negedge clk);
        f_start_i = 32'd777; f_stop_i = 32'd800; f_step_i = 32'd1; dwell_i = 16'd1;
        start_i = 1'b1; abort_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; abort_i = 1'b0;
        chk("abort_start_idle", {31'd0, busy_o}, 32'd0);
        chk("abort_start_phi", phi_inc_o, 32'd64);

        // dwell of zero acts as one
        start_sweep(32'd0, 32'd20, 32'd10, 16'd0, 2'b00);
        exp_q = '{32'd0, 32'd10, 32'd20};
        collect("dwell0", 20);
        @(negedge clk);
        chk("dwell0_done", {31'd0, done_o}, 32'd1);

        // reset mid-sweep, then re-prime with valid already high
        start_sweep(32'd0, 32'd30, 32'd10, 16'd3, 2'b10);
        exp_q = '{32'd0, 32'd0, 32'd0, 32'd10};
        collect("pre_reset", 20);
        reset_n = 1'b0;
        #1;
        chk("midrst_phi", phi_inc_o, 32'd0);
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        chk("midrst_clken", {31'd0, clken_o}, 32'd0);
        chk("midrst_sweep_valid", {31'd0, sweep_valid_o}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        start_sweep(32'd3, 32'd4, 32'd1, 16'd2, 2'b00);
        push_rep(32'd3, 2); push_rep(32'd4, 2);
        collect("after_reset", 20);
        @(negedge clk);
        chk("after_reset_done", {31'd0, done_o}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
